// File: rtl/icache_pkg.sv
// Shared types, response codes and address-split width helpers for the burst-refill instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RESP    = 2'd1,
        S_MISS_AR = 2'd2,
        S_REFILL  = 2'd3
    } state_e;

    localparam logic [2:0] RESP_OKAY = 3'd0;
    localparam logic [2:0] RESP_ERR  = 3'd2;

    function automatic int unsigned off_w(input int unsigned line_words);
        return unsigned'($clog2(line_words)) + 32'd2;
    endfunction

    function automatic int unsigned idx_w(input int unsigned set_num);
        return unsigned'($clog2(set_num));
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_len, input int unsigned set_num,
                                          input int unsigned line_words);
        return addr_len - idx_w(set_num) - off_w(line_words);
    endfunction

endpackage

// File: rtl/icache_data_bank.sv
// One way of line storage: synchronous SRAM model, active-low CEN/WEN, whole-line write, Q holds when idle.
module icache_data_bank #(
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 cen,
    input  logic                 wen,
    input  logic [IDX_W-1:0]     addr,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] q
);

    localparam int unsigned DEPTH = 32'd1 << IDX_W;

    logic [LINE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[addr] <= wdata;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/rand_lfsr_8_bit.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used for pseudo-random victim choice.
module rand_lfsr_8_bit (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] lfsr_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_out <= 8'h01;
        end else begin
            lfsr_out <= {lfsr_out[6:0], lfsr_out[7] ^ lfsr_out[5] ^ lfsr_out[4] ^ lfsr_out[3]};
        end
    end

endmodule

// File: rtl/icache_burst.sv
// N-way set-associative instruction cache with single-burst line refill, fence_i invalidate-all
// and hit/access counters.
module icache_burst
    import icache_pkg::*;
#(
    parameter int unsigned WAY_NUM    = 4,
    parameter int unsigned SET_NUM    = 64,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_LEN   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                IF_reg_inst_flush,
    input  logic                fence_i,
    output logic                fence_done,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_LEN-3:0] ifu_raddr,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [31:0]         ifu_rdata,
    output logic [2:0]          ifu_rresp,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    output logic [ADDR_LEN-1:0] mem_araddr,
    output logic [7:0]          mem_arlen,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    input  logic [31:0]         mem_rdata,
    input  logic [2:0]          mem_rresp,
    input  logic                mem_rlast,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         access_cnt
);

    localparam int unsigned OFF_W     = off_w(LINE_WORDS);
    localparam int unsigned IDX_W     = idx_w(SET_NUM);
    localparam int unsigned TAG_W     = tag_w(ADDR_LEN, SET_NUM, LINE_WORDS);
    localparam int unsigned WSEL_W    = OFF_W - 2;
    localparam int unsigned LINE_BITS = LINE_WORDS * 32;
    localparam int unsigned WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    state_e state_q, state_d;

    logic [TAG_W-1:0]  tag_c, tag_r;
    logic [IDX_W-1:0]  idx_c, idx_r;
    logic [WSEL_W-1:0] wsel_c, wsel_r;
    logic [TAG_W-1:0]  tag_arr [WAY_NUM][SET_NUM];
    logic [WAY_NUM-1:0][SET_NUM-1:0] valid_q;

    logic                       hit_c, accept_c, fence_c, beat_c, last_c, err_c, alloc_c;
    logic [WAY_W-1:0]           hit_way_c, hit_way_q, victim_c;
    logic                       resp_hit_q, rvalid_q, arvalid_q, fence_done_q, err_q;
    logic [31:0]                rdata_q, hit_cnt_q, access_cnt_q;
    logic [2:0]                 rresp_q;
    logic [WSEL_W-1:0]          beat_q;
    logic [LINE_WORDS-1:0][31:0] line_buf, fill_line_c;
    logic [7:0]                 lfsr;
    logic [LINE_BITS-1:0]       bank_q [WAY_NUM];
    logic [IDX_W-1:0]           bank_addr;

    assign wsel_c = ifu_raddr[WSEL_W-1:0];
    assign idx_c  = ifu_raddr[WSEL_W +: IDX_W];
    assign tag_c  = ifu_raddr[WSEL_W+IDX_W +: TAG_W];

    rand_lfsr_8_bit u_lfsr (.clk(clk), .rst_n(rst_n), .lfsr_out(lfsr));

    // Lookup and victim choice; descending loops leave the lowest matching way.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = WAY_W'(32'(lfsr) % WAY_NUM);
        for (int w = int'(WAY_NUM) - 1; w >= 0; w--) begin
            if (valid_q[w][idx_c] && (tag_arr[w][idx_c] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!valid_q[w][idx_r]) begin
                victim_c = WAY_W'(w);
            end
        end
    end

    assign ifu_arready = (state_q == S_IDLE) && !fence_i;
    assign accept_c    = ifu_arready && ifu_arvalid;
    assign fence_c     = (state_q == S_IDLE) && fence_i && !fence_done_q;
    assign beat_c      = (state_q == S_REFILL) && mem_rvalid;
    assign last_c      = beat_c && mem_rlast;
    assign err_c       = err_q || (mem_rresp != RESP_OKAY);
    assign alloc_c     = last_c && !err_c;

    always_comb begin
        fill_line_c         = line_buf;
        fill_line_c[beat_q] = mem_rdata;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept_c) state_d = (IF_reg_inst_flush || hit_c) ? S_RESP : S_MISS_AR;
            S_MISS_AR: if (mem_arready) state_d = S_REFILL;
            S_REFILL:  if (last_c) state_d = S_RESP;
            S_RESP:    if (ifu_rready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign bank_addr = (state_q == S_REFILL) ? idx_r : idx_c;

    for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
        logic wr;
        assign wr = alloc_c && (victim_c == WAY_W'(g));
        icache_data_bank #(.IDX_W(IDX_W), .LINE_BITS(LINE_BITS)) u_bank (
            .clk   (clk),
            .cen   (!((accept_c && !IF_reg_inst_flush) || wr)),
            .wen   (!wr),
            .addr  (bank_addr),
            .wdata (fill_line_c),
            .q     (bank_q[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tag array has no reset: entries are only trusted behind their valid bit.
    always_ff @(posedge clk) begin
        if (alloc_c) begin
            tag_arr[victim_c][idx_r] <= tag_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            tag_r        <= '0;
            idx_r        <= '0;
            wsel_r       <= '0;
            hit_way_q    <= '0;
            resp_hit_q   <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            fence_done_q <= 1'b0;
            hit_cnt_q    <= '0;
            access_cnt_q <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            line_buf     <= '0;
        end else begin
            fence_done_q <= fence_c;
            rvalid_q     <= (state_d == S_RESP);
            arvalid_q    <= (state_d == S_MISS_AR);
            if (fence_c) begin
                valid_q <= '0;
            end
            if (accept_c) begin
                tag_r      <= tag_c;
                idx_r      <= idx_c;
                wsel_r     <= wsel_c;
                rdata_q    <= '0;
                rresp_q    <= RESP_OKAY;
                resp_hit_q <= 1'b0;
                if (!IF_reg_inst_flush) begin
                    access_cnt_q <= access_cnt_q + 32'd1;
                    if (hit_c) begin
                        hit_cnt_q  <= hit_cnt_q + 32'd1;
                        hit_way_q  <= hit_way_c;
                        resp_hit_q <= 1'b1;
                    end
                end
            end
            if (beat_c) begin
                line_buf[beat_q] <= mem_rdata;
                beat_q           <= beat_q + WSEL_W'(1);
                err_q            <= err_c;
            end
            // Last beat: respond from the assembled line, allocate only when the burst was clean.
            if (last_c) begin
                beat_q  <= '0;
                err_q   <= 1'b0;
                rdata_q <= fill_line_c[wsel_r];
                rresp_q <= err_c ? RESP_ERR : RESP_OKAY;
                if (!err_c) begin
                    valid_q[victim_c][idx_r] <= 1'b1;
                end
            end
        end
    end

    assign ifu_rvalid  = rvalid_q;
    assign ifu_rdata   = resp_hit_q ? bank_q[hit_way_q][{wsel_r, 5'd0} +: 32] : rdata_q;
    assign ifu_rresp   = rresp_q;
    assign mem_arvalid = arvalid_q;
    assign mem_araddr  = {tag_r, idx_r, OFF_W'(0)};
    assign mem_arlen   = 8'(LINE_WORDS - 1);
    assign mem_rready  = 1'b1;
    assign fence_done  = fence_done_q;
    assign hit_cnt     = hit_cnt_q;
    assign access_cnt  = access_cnt_q;

endmodule

// File: tb/tb_icache_burst.sv
// Directed self-checking bench for icache_burst: vector table plus eviction and fence sequences.
module tb_icache_burst;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IF_reg_inst_flush = 1'b0;
    logic        fence_i = 1'b0;
    logic        fence_done;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [29:0] ifu_raddr = '0;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b0;
    logic [31:0] ifu_rdata;
    logic [2:0]  ifu_rresp;
    logic        mem_arvalid;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_araddr;
    logic [7:0]  mem_arlen;
    logic        mem_rvalid = 1'b0;
    logic        mem_rready;
    logic [31:0] mem_rdata = '0;
    logic [2:0]  mem_rresp = '0;
    logic        mem_rlast = 1'b0;
    logic [31:0] hit_cnt, access_cnt;

    int total = 0;
    int bad = 0;
    int exp_acc = 0;
    int exp_hit = 0;

    always #5 clk = ~clk;

    icache_burst dut (
        .clk(clk), .rst_n(rst_n), .IF_reg_inst_flush(IF_reg_inst_flush),
        .fence_i(fence_i), .fence_done(fence_done),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_raddr(ifu_raddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arlen(mem_arlen), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .hit_cnt(hit_cnt), .access_cnt(access_cnt)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        flush;
        logic        miss;
        int          bad_beat;
        int          hold;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {30'd0, a[3:2]} + 32'd1;
        if (a[31:4] == 28'h8000000) return k * 32'h11;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fetch(input string nm, input logic [31:0] baddr, input logic flush,
                         input logic exp_miss, input logic known, input int bad_beat,
                         input int hold, output logic missed);
        logic [31:0] line, exp_data;
        logic        err;
        int          n;
        line = {baddr[31:4], 4'h0};
        err  = (bad_beat >= 0) && (bad_beat < 4);
        ifu_raddr = baddr[31:2];
        ifu_arvalid = 1'b1;
        IF_reg_inst_flush = flush;
        n = 0;
        while (!ifu_arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_arready"}, 64'(ifu_arready), 64'd1);
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        IF_reg_inst_flush = 1'b0;
        missed = mem_arvalid;
        if (known) chk({nm, "_path"}, {62'd0, mem_arvalid, ifu_rvalid}, exp_miss ? 64'd2 : 64'd1);
        if (mem_arvalid) begin
            chk({nm, "_araddr"}, 64'(mem_araddr), 64'(line));
            chk({nm, "_arlen"}, 64'(mem_arlen), 64'd3);
            mem_arready = 1'b1;
            @(posedge clk); #1;
            mem_arready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(line + 32'(4 * k));
                mem_rresp  = (k == bad_beat) ? 3'd2 : 3'd0;
                mem_rlast  = (k == 3);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b0;
            mem_rlast  = 1'b0;
            mem_rresp  = 3'd0;
            chk({nm, "_refill_lat"}, 64'(ifu_rvalid), 64'd1);
        end else begin
            n = 0;
            while (!ifu_rvalid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk({nm, "_rvalid"}, 64'(ifu_rvalid), 64'd1);
        end
        exp_data = flush ? 32'd0 : mem_word(baddr);
        if (!(missed && err)) chk({nm, "_rdata"}, 64'(ifu_rdata), 64'(exp_data));
        chk({nm, "_rresp"}, 64'(ifu_rresp), (missed && err) ? 64'd2 : 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({nm, "_hold"}, {31'd0, ifu_rvalid, ifu_rdata}, {31'd1, exp_data});
        end
        ifu_rready = 1'b1;
        @(posedge clk); #1;
        ifu_rready = 1'b0;
        chk({nm, "_rvalid_drop"}, 64'(ifu_rvalid), 64'd0);
        if (!flush) begin
            exp_acc++;
            if (known ? !exp_miss : !missed) exp_hit++;
        end
        chk({nm, "_access_cnt"}, 64'(access_cnt), 64'(exp_acc));
        chk({nm, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hit));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        m;
        logic        found;
        logic [31:0] ev [5];

        vecs[0] = '{addr: 32'h8000_0004, flush: 1'b0, miss: 1'b1, bad_beat: -1, hold: 0};
        vecs[1] = '{addr: 32'h8000_000C, flush: 1'b0, miss: 1'b0, bad_beat: -1, hold: 0};
        vecs[2] = '{addr: 32'h8000_0008, flush: 1'b1, miss: 1'b0, bad_beat: -1, hold: 5};
        vecs[3] = '{addr: 32'h8000_1010, flush: 1'b0, miss: 1'b1, bad_beat: 2,  hold: 0};
        vecs[4] = '{addr: 32'h8000_1010, flush: 1'b0, miss: 1'b1, bad_beat: -1, hold: 2};
        vecs[5] = '{addr: 32'h8000_1014, flush: 1'b0, miss: 1'b0, bad_beat: -1, hold: 0};

        #2;
        chk("rst_arready", 64'(ifu_arready), 64'd1);
        chk("rst_outputs", {56'd0, ifu_rvalid, ifu_rresp, mem_arvalid, fence_done, 2'd0}, 64'd0);
        chk("rst_rdata", 64'(ifu_rdata), 64'd0);
        chk("rst_counters", {hit_cnt, access_cnt}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].flush, vecs[i].miss, 1'b1,
                  vecs[i].bad_beat, vecs[i].hold, m);
        end

        // WAY_NUM+1 lines on set 5: four cold fills, all resident, fifth evicts one.
        for (int k = 0; k < 5; k++) ev[k] = 32'h9000_0050 + 32'(k) * 32'h400;
        for (int k = 0; k < 4; k++) fetch($sformatf("fill%0d", k), ev[k], 1'b0, 1'b1, 1'b1, -1, 0, m);
        for (int k = 0; k < 4; k++) fetch($sformatf("res%0d", k), ev[k] + 32'd8, 1'b0, 1'b0, 1'b1, -1, 0, m);
        fetch("fill4", ev[4] + 32'd4, 1'b0, 1'b1, 1'b1, -1, 0, m);
        fetch("res4", ev[4] + 32'd12, 1'b0, 1'b0, 1'b1, -1, 0, m);
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found) begin
                fetch($sformatf("probe%0d", k), ev[k], 1'b0, 1'b0, 1'b0, -1, 0, m);
                found = m;
            end
        end
        chk("evicted_line_misses", 64'(found), 64'd1);

        // Invalidate-all after hits.
        fetch("pre_fence0", 32'h8000_000C, 1'b0, 1'b0, 1'b1, -1, 0, m);
        fetch("pre_fence1", 32'h8000_1018, 1'b0, 1'b0, 1'b1, -1, 0, m);
        fence_i = 1'b1;
        #1;
        chk("fence_arready", 64'(ifu_arready), 64'd0);
        @(posedge clk); #1;
        chk("fence_done_pulse", 64'(fence_done), 64'd1);
        fence_i = 1'b0;
        @(posedge clk); #1;
        chk("fence_done_low", 64'(fence_done), 64'd0);
        fetch("post_fence0", 32'h8000_0004, 1'b0, 1'b1, 1'b1, -1, 0, m);
        fetch("post_fence1", 32'h8000_1018, 1'b0, 1'b1, 1'b1, -1, 0, m);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_burst.md
# icache_burst

Parametrised next-generation instruction cache between the IFU and the memory-side AXI-style read port. It is N-way set-associative with configurable set count and line length. A miss is refilled with a single burst request (arlen/rlast) instead of per-word reads. Replacement prefers invalid ways, a fence_i input invalidates the whole cache, and hit/access counters are exposed as ports.

## Interface
Parameters:
- WAY_NUM, 4, number of ways; power of two, 1..8
- SET_NUM, 64, sets per way; power of two, ≥2
- LINE_WORDS, 4, 32-bit words per line; 4 or 8
- ADDR_LEN, 32, address width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- IF_reg_inst_flush  in  1  discard the request being accepted
- fence_i  in  1  invalidate-all request (level, held until fence_done)
- fence_done  out  1  one-cycle pulse when invalidation has completed
- ifu_arvalid / ifu_arready  in/out  1  IFU request handshake
- ifu_raddr  in  ADDR_LEN-2  word address
- ifu_rvalid / ifu_rready  out/in  1  IFU response handshake
- ifu_rdata  out  32  instruction
- ifu_rresp  out  3  0 = OKAY, 2 = error
- mem_arvalid / mem_arready  out/in  1  refill address handshake
- mem_araddr  out  ADDR_LEN  line-aligned address
- mem_arlen  out  8  LINE_WORDS-1
- mem_rvalid  in  1  refill data valid
- mem_rready  out  1  tied to 1
- mem_rdata  in  32  refill data
- mem_rresp  in  3  refill response
- mem_rlast  in  1  last beat of the burst
- hit_cnt, access_cnt  out  32  performance counters; wrap at 2^32

## Operation
- Address split: OFF = log2(LINE_WORDS)+2, IDX = log2(SET_NUM), TAG = ADDR_LEN-IDX-OFF.
- The word select is raddr[OFF-1:2].
- States are IDLE, RESP, MISS_AR and REFILL.

IDLE (ifu_arready = 1):
- fence_i has priority over ifu_arvalid. When fence_i is high, ifu_arready is 0 that cycle, all valid bits clear at the clock edge, and fence_done pulses on the next cycle.
- On accept with IF_reg_inst_flush = 1: no lookup and no counter change. Go to RESP with rdata = 0 and rresp = 0.
- On accept with a hit (tag compare is combinational against ifu_raddr): access_cnt and hit_cnt increment, the hit way is registered, and the state goes to RESP.
- On accept with a miss: access_cnt increments, the address is registered, and the state goes to MISS_AR.

MISS_AR:
- mem_arvalid = 1, mem_araddr = {tag, idx, OFF'b0}.
- On mem_arready, go to REFILL.

REFILL:
- Each mem_rvalid beat is stored into the line buffer at the beat counter position; the counter increments per beat.
- Any beat with mem_rresp ≠ 0 sets a sticky error flag.
- On the rlast beat with no error: write the buffer to the data array of the victim way and set tag and valid for it.
- On the rlast beat with error: do not allocate, and respond with rresp = 2.
- Go to RESP. The refill response word is taken from the buffer.

Victim selection:
- The lowest-index invalid way in the set is chosen.
- If all ways are valid, the choice is rand_lfsr_8_bit output mod WAY_NUM.

RESP:
- ifu_rvalid = 1. rdata and rresp are held stable until ifu_rready.
- On the handshake, return to IDLE.

Other rules:
- IF_reg_inst_flush while in MISS_AR or REFILL is ignored. The burst completes and the line is allocated.
- fence_i raised outside IDLE waits until the next IDLE cycle.

## Timing
- Reset values:
  - state IDLE, ifu_arready = 1
  - ifu_rvalid = 0, ifu_rdata = 0, ifu_rresp = 0
  - mem_arvalid = 0, fence_done = 0
  - all valid bits 0, counters 0
- Hit or flush: accept in cycle N, ifu_rvalid in N+1. The next accept is possible in the cycle after the rready handshake.
- Miss: mem_arvalid in N+1. The response is valid 1 cycle after the rlast beat.
- The data array has a synchronous read. The address is presented at accept and Q is valid in N+1. Q holds while the array is not enabled.
- A refill write and the following lookup never collide: refill completes and RESP is traversed before IDLE is re-entered.
- Reset asserted mid-burst: the FSM returns to IDLE immediately and no partial line is allocated. The memory side must also be reset.

## Structure
- Shared package icache_pkg holds:
  - the state enum
  - RESP_OKAY = 3'd0 and RESP_ERR = 3'd2
  - the OFF, IDX and TAG width functions
- Sub-module icache_data_bank: one instance per way, SET_NUM × (LINE_WORDS·32) synchronous SRAM model with CEN/WEN, whole-line write and output hold.
- Tag and valid arrays are flops in the top level, so invalidate-all completes in one cycle.
- rand_lfsr_8_bit is reused.

## Test plan
- Cold miss at 0x8000_0004, burst returns 0x11,0x22,0x33,0x44 → mem_araddr = 0x8000_0000, arlen = 3, rdata = 0x22, access_cnt = 1, hit_cnt = 0.
- Repeat fetch of 0x8000_000C → rvalid 1 cycle after accept, rdata = 0x44, no mem_arvalid, hit_cnt = 1.
- Fill WAY_NUM+1 lines mapping to index 0 → first WAY_NUM fills use ways 0..WAY_NUM-1 in order, the last evicts an LFSR-chosen way, and a refetch of the evicted line misses.
- Refill with beat 2 rresp = 2 → ifu_rresp = 2, and a refetch of the same line misses again.
- Assert fence_i after hits → fence_done pulses once, the next fetch of each line misses, and ifu_arready is 0 during the invalidate cycle.
- Accept with IF_reg_inst_flush = 1 → rvalid next cycle with rdata = 0, counters unchanged; rready held low for 5 cycles → rvalid and rdata held stable.
